// File: rtl/vga_sync_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen_pkg
// Purpose  : Shared definitions for the VGA sync generator: the region
//            state encoding used by both axis FSMs and the default 640x480
//            timing constants (porch/sync widths and line/frame totals).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_sync_gen_pkg;

  // Region of one axis within its line/frame period.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } regionState_t;

  // Default horizontal timing, in pixel clocks.
  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;  // 800

  // Default vertical timing, in lines.
  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 29;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;  // 521

  // Counter input width shared by both axes.
  localparam int C_CNT_W = 10;

endpackage : vga_sync_gen_pkg
`default_nettype wire

// File: rtl/vga_axis_fsm.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_fsm
// Purpose  : Region FSM for one display axis. The next region is decoded
//            directly from the external position counter every clock; any
//            count past the end of the period parks the axis in BACK and
//            raises outOfRange for that cycle.
// Ports    : Clk        - clock, rising edge
//            Reset      - synchronous, active-high; state returns to BACK
//            cnt        - position counter for this axis
//            stateNext  - region the axis enters at the next edge
//            state      - registered region
//            outOfRange - cnt lies beyond the last legal position
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_fsm
  import vga_sync_gen_pkg::*;
#(
  parameter int ACTIVE = C_H_ACTIVE,
  parameter int FP     = C_H_FP,
  parameter int SYNC   = C_H_SYNC,
  parameter int BP     = C_H_BP,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] cnt,
  output regionState_t     stateNext,
  output regionState_t     state,
  output logic             outOfRange
);

  // Last position of each region; the period total must fit in CNT_W bits.
  localparam logic [CNT_W-1:0] C_ACTIVE_LAST = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] C_FRONT_LAST  = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] C_SYNC_LAST   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] C_LAST        = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_BACK;
    end else begin
      state <= stateNext;
    end
  end

  // The counter is authoritative, so the decode ignores the current state;
  // a wrap from the last position to 0 is simply BACK -> ACTIVE.
  always_comb begin
    stateNext  = ST_BACK;
    outOfRange = 1'b0;
    if (cnt <= C_ACTIVE_LAST) begin
      stateNext = ST_ACTIVE;
    end else if (cnt <= C_FRONT_LAST) begin
      stateNext = ST_FRONT;
    end else if (cnt <= C_SYNC_LAST) begin
      stateNext = ST_SYNC;
    end else if (cnt <= C_LAST) begin
      stateNext = ST_BACK;
    end else begin
      stateNext  = ST_BACK;
      outOfRange = 1'b1;
    end
  end

endmodule : vga_axis_fsm
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : VGA sync/timing decoder. Takes externally generated pixel and
//            line counters and produces registered syncs, active-video flag,
//            active-area coordinates, line/frame start pulses, a sticky
//            range error and an optional frame counter. Every output lags
//            the counter inputs by exactly one clock.
// Ports    : Clk           - clock, rising edge
//            Reset         - synchronous, active-high
//            cntHorizontal - pixel column, 0..799
//            cntVertical   - line, 0..520
//            hsync, vsync  - active-low syncs
//            video_on      - both axes in their active region
//            pixel_x/y     - active-area coordinates, 0 outside active video
//            frame_start   - one-clock pulse on entry to (0,0)
//            line_start    - one-clock pulse on entry to column 0
//            range_err     - sticky, a counter went past its period
//            frame_cnt     - frame counter
// Macro    : VGA_FRAME_CNT_EN - when defined, frame_cnt counts frame_start
//            pulses modulo 256; otherwise frame_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] cntHorizontal,
  input  logic [9:0] cntVertical,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       line_start,
  output logic       range_err,
  output logic [7:0] frame_cnt
);

  // Previous-count registers restart at the last legal position so that a
  // (0,0) right after Reset reads as a fresh frame.
  localparam logic [9:0] C_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] C_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  regionState_t w_hStateNext, w_hState;
  regionState_t w_vStateNext, w_vState;
  logic         w_hOutOfRange, w_vOutOfRange;
  logic         w_videoNext, w_lineEdge, w_frameEdge;

  logic       r_hsync, r_vsync, r_videoOn;
  logic [9:0] r_pixelX, r_pixelY;
  logic       r_frameStart, r_lineStart, r_rangeErr;
  logic [9:0] r_prevH, r_prevV;

  vga_axis_fsm #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (10)
  ) u_hAxis (
    .Clk        (Clk),
    .Reset      (Reset),
    .cnt        (cntHorizontal),
    .stateNext  (w_hStateNext),
    .state      (w_hState),
    .outOfRange (w_hOutOfRange)
  );

  vga_axis_fsm #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (10)
  ) u_vAxis (
    .Clk        (Clk),
    .Reset      (Reset),
    .cnt        (cntVertical),
    .stateNext  (w_vStateNext),
    .state      (w_vState),
    .outOfRange (w_vOutOfRange)
  );

  assign w_videoNext = (w_hStateNext == ST_ACTIVE) && (w_vStateNext == ST_ACTIVE);

  // Edges are detected on the counter value itself, so a counter that dwells
  // on 0 for several clocks (pixel-tick slower than Clk) pulses only once.
  assign w_lineEdge  = (cntHorizontal == 10'd0) && (r_prevH != 10'd0);
  assign w_frameEdge = (cntHorizontal == 10'd0) && (cntVertical == 10'd0) &&
                       ((r_prevH != 10'd0) || (r_prevV != 10'd0));

  // Outputs are loaded from the next-state decode on the same edge that the
  // axis FSMs advance, so they always agree with the registered FSM states.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_videoOn    <= 1'b0;
      r_pixelX     <= 10'd0;
      r_pixelY     <= 10'd0;
      r_frameStart <= 1'b0;
      r_lineStart  <= 1'b0;
      r_rangeErr   <= 1'b0;
      r_prevH      <= C_H_LAST;
      r_prevV      <= C_V_LAST;
    end else begin
      r_hsync      <= (w_hStateNext != ST_SYNC);
      r_vsync      <= (w_vStateNext != ST_SYNC);
      r_videoOn    <= w_videoNext;
      r_pixelX     <= w_videoNext ? cntHorizontal : 10'd0;
      r_pixelY     <= w_videoNext ? cntVertical   : 10'd0;
      r_frameStart <= w_frameEdge;
      r_lineStart  <= w_lineEdge;
      r_rangeErr   <= r_rangeErr | w_hOutOfRange | w_vOutOfRange;
      r_prevH      <= cntHorizontal;
      r_prevV      <= cntVertical;
    end
  end

  // Registered flags must stay coherent with the registered axis states.
  a_stateCoherent : assert property (@(posedge Clk) disable iff (Reset)
    (r_videoOn == ((w_hState == ST_ACTIVE) && (w_vState == ST_ACTIVE))) &&
    (r_hsync   == (w_hState != ST_SYNC)) &&
    (r_vsync   == (w_vState != ST_SYNC)));

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frameCnt;

  // Advances on the same edge frame_start rises; wraps naturally at 255.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frameCnt <= 8'd0;
    end else if (w_frameEdge) begin
      r_frameCnt <= r_frameCnt + 8'd1;
    end
  end

  assign frame_cnt = r_frameCnt;
`else
  assign frame_cnt = 8'd0;
`endif

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_videoOn;
  assign pixel_x     = r_pixelX;
  assign pixel_y     = r_pixelY;
  assign frame_start = r_frameStart;
  assign line_start  = r_lineStart;
  assign range_err   = r_rangeErr;

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Self-checking bench for vga_sync_gen. Each driven cycle pushes
//            the expected outputs (from a reference model of the 640x480
//            timing) onto a scoreboard, which is popped and compared one
//            clock later. Honours VGA_FRAME_CNT_EN for frame_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  logic       Clk;
  logic       Reset;
  logic [9:0] cntHorizontal;
  logic [9:0] cntVertical;
  logic       hsync, vsync, video_on, frame_start, line_start, range_err;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] frame_cnt;

  typedef struct {
    int hs;
    int vs;
    int vid;
    int px;
    int py;
    int fs;
    int ls;
    int err;
    int fcnt;
  } expect_t;

  expect_t scoreboard[$];

  int totalCount = 0;
  int badCount   = 0;

  // Reference model state
  int mPrevH = 799;
  int mPrevV = 520;
  int mErr   = 0;
  int mFcnt  = 0;

  vga_sync_gen dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .cntHorizontal (cntHorizontal),
    .cntVertical   (cntVertical),
    .hsync         (hsync),
    .vsync         (vsync),
    .video_on      (video_on),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .frame_start   (frame_start),
    .line_start    (line_start),
    .range_err     (range_err),
    .frame_cnt     (frame_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input int got, input int want);
    totalCount++;
    if (got != want) begin
      badCount++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Horizontal region: 0 active, 1 front, 2 sync, 3 back (or out of range)
  function automatic int hRegion(input int h);
    if (h < 640) return 0;
    if (h < 656) return 1;
    if (h < 752) return 2;
    return 3;
  endfunction

  function automatic int vRegion(input int v);
    if (v < 480) return 0;
    if (v < 490) return 1;
    if (v < 492) return 2;
    return 3;
  endfunction

  // Drive one clock of stimulus, predict, then compare after the edge.
  task automatic step(input logic rst, input int h, input int v, input string tag);
    expect_t e;
    expect_t got;
    @(negedge Clk);
    Reset         = rst;
    cntHorizontal = 10'(h);
    cntVertical   = 10'(v);
    if (rst) begin
      e = '{hs: 1, vs: 1, vid: 0, px: 0, py: 0, fs: 0, ls: 0, err: 0, fcnt: 0};
      mPrevH = 799;
      mPrevV = 520;
      mErr   = 0;
      mFcnt  = 0;
    end else begin
      e.hs  = (hRegion(h) == 2) ? 0 : 1;
      e.vs  = (vRegion(v) == 2) ? 0 : 1;
      e.vid = (hRegion(h) == 0 && vRegion(v) == 0) ? 1 : 0;
      e.px  = e.vid ? h : 0;
      e.py  = e.vid ? v : 0;
      e.ls  = (h == 0 && mPrevH != 0) ? 1 : 0;
      e.fs  = (h == 0 && v == 0 && !(mPrevH == 0 && mPrevV == 0)) ? 1 : 0;
      if (h > 799 || v > 520) mErr = 1;
      e.err = mErr;
`ifdef VGA_FRAME_CNT_EN
      if (e.fs == 1) mFcnt = (mFcnt + 1) % 256;
`endif
      e.fcnt = mFcnt;
      mPrevH = h;
      mPrevV = v;
    end
    scoreboard.push_back(e);
    @(posedge Clk);
    #1;
    if (scoreboard.size() == 0) begin
      checkVal({tag, ".scoreboard_empty"}, 0, 1);
    end else begin
      got = scoreboard.pop_front();
      checkVal({tag, ".hsync"},       int'(hsync),       got.hs);
      checkVal({tag, ".vsync"},       int'(vsync),       got.vs);
      checkVal({tag, ".video_on"},    int'(video_on),    got.vid);
      checkVal({tag, ".pixel_x"},     int'(pixel_x),     got.px);
      checkVal({tag, ".pixel_y"},     int'(pixel_y),     got.py);
      checkVal({tag, ".frame_start"}, int'(frame_start), got.fs);
      checkVal({tag, ".line_start"},  int'(line_start),  got.ls);
      checkVal({tag, ".range_err"},   int'(range_err),   got.err);
      checkVal({tag, ".frame_cnt"},   int'(frame_cnt),   got.fcnt);
    end
  endtask

  initial begin
    int lsPulses;
    Reset         = 1'b1;
    cntHorizontal = 10'd0;
    cntVertical   = 10'd0;

    step(1'b1, 0, 0, "reset0");
    step(1'b1, 5, 5, "reset1");

    // First frame start straight out of reset
    step(1'b0, 0, 0, "first_frame");
    checkVal("first_frame.fs_direct", int'(frame_start), 1);
    step(1'b0, 1, 0, "px1");
    step(1'b0, 639, 479, "last_active");
    step(1'b0, 640, 479, "h_front");

    // Horizontal sync window
    step(1'b0, 656, 100, "hsync_on");
    checkVal("hsync_on.direct", int'(hsync), 0);
    step(1'b0, 751, 100, "hsync_last");
    step(1'b0, 752, 100, "hsync_off");
    checkVal("hsync_off.direct", int'(hsync), 1);
    step(1'b0, 799, 100, "h_end");
    step(1'b0, 0, 101, "h_wrap");

    // Vertical sync window
    step(1'b0, 700, 489, "v_front");
    step(1'b0, 700, 490, "vsync_on0");
    step(1'b0, 700, 491, "vsync_on1");
    step(1'b0, 700, 492, "vsync_off");

    // Counter dwelling on 0 at pixel-tick rate: exactly one line_start
    lsPulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 5, "h_dwell");
      if (line_start) lsPulses++;
    end
    checkVal("h_dwell.pulses", lsPulses, 1);

    // Legal frame wrap
    step(1'b0, 799, 520, "frame_end");
    step(1'b0, 0, 0, "frame_wrap");

    // Out-of-range handling and stickiness
    step(1'b0, 900, 10, "h_oor");
    checkVal("h_oor.err_direct", int'(range_err), 1);
    step(1'b0, 100, 10, "err_sticky");
    step(1'b0, 300, 600, "v_oor");
    step(1'b0, 656, 10, "err_sticky2");
    step(1'b1, 0, 0, "err_clear");
    step(1'b0, 0, 0, "after_clear");

    // Mid-frame reset: no carried-over pulse
    step(1'b0, 10, 20, "pre_midreset");
    step(1'b1, 0, 0, "midreset");
    step(1'b0, 5, 0, "post_midreset");

    // Random legal positions
    for (int i = 0; i < 150; i++) begin
      step(1'b0, int'($urandom_range(799, 0)), int'($urandom_range(520, 0)), "rand");
    end

    // 257 frame starts from a clean reset
    step(1'b1, 0, 0, "fc_reset");
    for (int i = 0; i < 257; i++) begin
      step(1'b0, 0, 0, "fc_start");
      step(1'b0, 5, 0, "fc_gap");
    end
`ifdef VGA_FRAME_CNT_EN
    checkVal("frame_cnt_257", int'(frame_cnt), 1);
`else
    checkVal("frame_cnt_257", int'(frame_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule : tb_vga_sync_gen
`default_nettype wire
